// File: rtl/a2d_scan_pkg.sv
// a2d_scan_pkg: shared types and helpers for the A2D scan sequencer
package a2d_scan_pkg;

    localparam int CMD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PAUSE,
        S_READ,
        S_ACC
    } state_t;

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'b0};
    endfunction

endpackage

// File: rtl/a2d_scan_ctrl_if.sv
// a2d_scan_ctrl_if: command/response link between the sequencer and the SPI master
interface a2d_scan_ctrl_if;
    import a2d_scan_pkg::*;

    logic             wrt;
    logic [CMD_W-1:0] cmd;
    logic             done;
    logic [15:0]      rd_data;

    modport master (output wrt, cmd, input done, rd_data);
    modport slave  (input wrt, cmd, output done, rd_data);

endinterface

// File: rtl/a2d_avg_acc.sv
// a2d_avg_acc: sums 2^AVG_LOG2 samples and yields their floored mean
module a2d_avg_acc #(
    parameter int  RES_W    = 12,
    parameter int  AVG_LOG2 = 0,
    localparam int CNT_W    = AVG_LOG2 > 0 ? AVG_LOG2 : 1,
    localparam int ACC_W    = RES_W + AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic             commit,
    input  logic [RES_W-1:0] sample,
    output logic             last,
    output logic [RES_W-1:0] avg
);
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The running sum plus the sample in hand always fits ACC_W bits.
    assign sum  = acc_q + ACC_W'(sample);
    assign avg  = RES_W'(sum >> AVG_LOG2);
    assign last = cnt_q == CNT_W'((1 << AVG_LOG2) - 1);

    // Add a sample and count it, or drop back to empty after a commit.
    always_comb begin
        acc_d = (clr || commit) ? '0 : add ? sum : acc_q;
        cnt_d = (clr || commit) ? '0 : add ? cnt_q + 1'b1 : cnt_q;
    end

    // Accumulator and sample-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// a2d_scan_ctrl: round-robin A2D channel sequencer driving a 16-bit SPI master
module a2d_scan_ctrl
    import a2d_scan_pkg::*;
#(
    parameter int                  NUM_CH    = 3,
    parameter logic [NUM_CH*3-1:0] CH_MAP    = {3'd5, 3'd4, 3'd0},
    parameter int                  RES_W     = 12,
    parameter int                  AVG_LOG2  = 0,
    parameter int                  PAUSE_CYC = 1,
    localparam int                 SLOT_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    nxt,
    input  logic                    auto_en,
    a2d_scan_ctrl_if.master         spi,
    output logic [NUM_CH*RES_W-1:0] res,
    output logic [NUM_CH-1:0]       res_vld,
    output logic                    cnv_done,
    output logic [SLOT_W-1:0]       cnv_slot,
    output logic                    busy
);
    localparam int PCW = PAUSE_CYC > 1 ? $clog2(PAUSE_CYC) : 1;

    state_t                         state_q, state_d;
    logic [PCW-1:0]                 pcnt_q, pcnt_d;
    logic [SLOT_W-1:0]              ptr_q, ptr_d;
    logic [RES_W-1:0]               smp_q, smp_d;
    logic [CMD_W-1:0]               cmd_q, cmd_d;
    logic                           wrt_q, wrt_d;
    logic [NUM_CH-1:0][RES_W-1:0]   bank_q, bank_d;
    logic [NUM_CH-1:0]              vld_q, vld_d;
    logic                           cnv_q, cnv_d;
    logic [SLOT_W-1:0]              slot_q, slot_d;
    logic                           busy_q, busy_d;
    logic                           acc_add, acc_commit, acc_last;
    logic [RES_W-1:0]               acc_avg;
    logic                           unused_rd;

    assign spi.wrt   = wrt_q;
    assign spi.cmd   = cmd_q;
    assign res       = bank_q;
    assign res_vld   = vld_q;
    assign cnv_done  = cnv_q;
    assign cnv_slot  = slot_q;
    assign busy      = busy_q;
    assign unused_rd = ^spi.rd_data;

    a2d_avg_acc #(
        .RES_W    (RES_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == S_IDLE),
        .add    (acc_add),
        .commit (acc_commit),
        .sample (smp_q),
        .last   (acc_last),
        .avg    (acc_avg)
    );

    // Sequence command, pause, read-back and accumulate; commit after the last sample.
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        ptr_d      = ptr_q;
        cmd_d      = cmd_q;
        wrt_d      = 1'b0;
        bank_d     = bank_q;
        vld_d      = vld_q;
        cnv_d      = 1'b0;
        slot_d     = slot_q;
        acc_add    = 1'b0;
        acc_commit = 1'b0;
        smp_d      = (state_q == S_READ && spi.done) ? spi.rd_data[RES_W-1:0] : smp_q;
        case (state_q)
            S_IDLE: begin
                if (nxt || auto_en) begin
                    state_d = S_CMD;
                    wrt_d   = 1'b1;
                    cmd_d   = mk_cmd(CH_MAP[3*ptr_q +: 3]);
                end
            end
            S_CMD: begin
                if (spi.done) begin
                    state_d = S_PAUSE;
                    pcnt_d  = '0;
                end
            end
            S_PAUSE: begin
                state_d = (pcnt_q == PCW'(PAUSE_CYC - 1)) ? S_READ : S_PAUSE;
                wrt_d   = pcnt_q == PCW'(PAUSE_CYC - 1);
                pcnt_d  = pcnt_q + 1'b1;
            end
            S_READ: begin
                if (spi.done) state_d = S_ACC;
            end
            S_ACC: begin
                if (!acc_last) begin
                    acc_add = 1'b1;
                    state_d = S_CMD;
                    wrt_d   = 1'b1;
                end else begin
                    acc_commit    = 1'b1;
                    state_d       = S_IDLE;
                    cmd_d         = '0;
                    bank_d[ptr_q] = acc_avg;
                    vld_d[ptr_q]  = 1'b1;
                    cnv_d         = 1'b1;
                    slot_d        = ptr_q;
                    ptr_d         = (ptr_q == SLOT_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    // All state and outputs are registered; reset returns everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            ptr_q   <= '0;
            smp_q   <= '0;
            cmd_q   <= '0;
            wrt_q   <= 1'b0;
            bank_q  <= '0;
            vld_q   <= '0;
            cnv_q   <= 1'b0;
            slot_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ptr_q   <= ptr_d;
            smp_q   <= smp_d;
            cmd_q   <= cmd_d;
            wrt_q   <= wrt_d;
            bank_q  <= bank_d;
            vld_q   <= vld_d;
            cnv_q   <= cnv_d;
            slot_q  <= slot_d;
            busy_q  <= busy_d;
        end
    end

endmodule
